// File: rtl/exe_pkg.sv
// Shared encodings for the parametrised execute stage: ALU op codes,
// forwarding selects and the iterative multiplier state machine.
package exe_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // Offset of the link value written by JAL/JALR.
    localparam int LINK_OFFSET = 4;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle;
// returns the low XLEN bits of the product and waits in DONE while held.
module exe_mul_iter
    import exe_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            hold,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int STEPS = XLEN / MUL_BITS;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    mul_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  mcand_q;
    logic [XLEN-1:0]  mplier_q;
    logic [XLEN-1:0]  acc_q;
    logic [XLEN-1:0]  partial;

    // Only the low XLEN bits of the product are kept, so the signed and
    // unsigned interpretations give the same result.
    assign partial = mcand_q * XLEN'(mplier_q[MUL_BITS-1:0]);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (abort) begin
            state_q <= MUL_IDLE;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    acc_q    <= acc_q + partial;
                    mcand_q  <= mcand_q << MUL_BITS;
                    mplier_q <= mplier_q >> MUL_BITS;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (!hold) begin
                        state_q <= MUL_IDLE;
                    end
                end
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

    assign busy    = (state_q == MUL_RUN);
    assign done    = (state_q == MUL_DONE);
    assign product = acc_q;

endmodule

// File: rtl/exe_stage_param.sv
// Parametrised execute stage: forwarding, ALU, branch resolution, iterative
// MUL with pipeline hold, and the EX/MEM register with stall and flush.
module exe_stage_param
    import exe_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            MemReadE,
    input  logic            MemToRegE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUOpE,
    input  logic            MulE,
    input  logic            BEQ_E,
    input  logic            BNE_E,
    input  logic            JAL_E,
    input  logic            JALR_E,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallM,
    input  logic            FlushE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            BusyE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            MemReadM,
    output logic            MemToRegM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALU_ResultM,
    output logic [XLEN-1:0] WriteDataM
);

    localparam int SH_W = $clog2(XLEN);

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            mem_read;
        logic            mem_to_reg;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
    } exmem_t;

    exmem_t          exmem_d;
    exmem_t          exmem_q;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jalr_sum;
    logic            zero;
    logic            mul_start;
    logic            mul_busy;
    logic            mul_done;
    logic            mul_idle;
    logic            mul_bubble;
    logic [XLEN-1:0] mul_product;

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] mem_val
    );
        case (fwd_sel_t'(sel))
            FWD_WB:  fwd_mux = wb_val;
            FWD_MEM: fwd_mux = mem_val;
            default: fwd_mux = reg_val;
        endcase
    endfunction

    assign src_a = fwd_mux(ForwardAE, RD1_E, ResultW, exmem_q.alu_result);
    assign fwd_b = fwd_mux(ForwardBE, RD2_E, ResultW, exmem_q.alu_result);
    assign src_b = ALUSrcE ? Imm_E : fwd_b;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        alu_result = '0;
        case (alu_op_t'(ALUOpE))
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_ADD: alu_result = src_a + src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLL: alu_result = src_a << src_b[SH_W-1:0];
            ALU_SRL: alu_result = src_a >> src_b[SH_W-1:0];
            ALU_SUB: alu_result = src_a - src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            default: alu_result = '0;
        endcase
    end

    // Branch compare uses the same operands the ALU subtracts.
    assign zero      = (src_a == src_b);
    assign pc_plus4  = PCE + XLEN'(LINK_OFFSET);
    assign jalr_sum  = src_a + Imm_E;
    assign PCTargetE = JALR_E ? {jalr_sum[XLEN-1:1], 1'b0} : PCE + Imm_E;
    assign PCSrcE    = ~FlushE & ((BEQ_E & zero) | (BNE_E & ~zero) | JAL_E | JALR_E);

    assign mul_idle  = ~mul_busy & ~mul_done;
    assign mul_start = mul_idle & MulE & ~FlushE;

    exe_mul_iter #(
        .XLEN     (XLEN),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (FlushE),
        .hold    (StallM),
        .op_a    (src_a),
        .op_b    (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // A held DONE keeps the MUL in EX, so the front end must stay frozen too.
    assign BusyE      = mul_start | mul_busy | (mul_done & StallM);
    assign mul_bubble = ~mul_done & (MulE | mul_busy);

    always_comb begin
        exmem_d = exmem_q;
        if (!StallM) begin
            if (FlushE || mul_bubble) begin
                exmem_d = '0;
            end else begin
                exmem_d.reg_write  = RegWriteE;
                exmem_d.mem_write  = MemWriteE;
                exmem_d.mem_read   = MemReadE;
                exmem_d.mem_to_reg = MemToRegE;
                exmem_d.rd         = RD_E;
                exmem_d.write_data = fwd_b;
                if (mul_done) begin
                    exmem_d.alu_result = mul_product;
                end else if (JAL_E || JALR_E) begin
                    exmem_d.alu_result = pc_plus4;
                end else begin
                    exmem_d.alu_result = alu_result;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign RegWriteM   = exmem_q.reg_write;
    assign MemWriteM   = exmem_q.mem_write;
    assign MemReadM    = exmem_q.mem_read;
    assign MemToRegM   = exmem_q.mem_to_reg;
    assign RD_M        = exmem_q.rd;
    assign ALU_ResultM = exmem_q.alu_result;
    assign WriteDataM  = exmem_q.write_data;

endmodule

// File: tb/tb_exe_stage_param.sv
// Directed bench for exe_stage_param: a cycle-level reference model checked
// every cycle plus hand-computed expectations for each scenario.
module tb_exe_stage_param;

    localparam int XLEN       = 64;
    localparam int MUL_BITS   = 4;
    localparam int RUN_CYCLES = XLEN / MUL_BITS;

    logic            clk = 1'b0;
    logic            reset;
    logic            RegWriteE, MemWriteE, MemReadE, MemToRegE, ALUSrcE;
    logic [2:0]      ALUOpE;
    logic            MulE, BEQ_E, BNE_E, JAL_E, JALR_E;
    logic [63:0]     RD1_E, RD2_E, Imm_E, PCE, ResultW;
    logic [4:0]      RD_E;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            StallM, FlushE;
    logic            PCSrcE, BusyE;
    logic [63:0]     PCTargetE;
    logic            RegWriteM, MemWriteM, MemReadM, MemToRegM;
    logic [4:0]      RD_M;
    logic [63:0]     ALU_ResultM, WriteDataM;

    int checks   = 0;
    int failures = 0;

    exe_stage_param #(.XLEN(XLEN), .MUL_BITS(MUL_BITS)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
        .MemToRegE(MemToRegE), .ALUSrcE(ALUSrcE), .ALUOpE(ALUOpE), .MulE(MulE),
        .BEQ_E(BEQ_E), .BNE_E(BNE_E), .JAL_E(JAL_E), .JALR_E(JALR_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_E(Imm_E), .PCE(PCE), .RD_E(RD_E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .StallM(StallM), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .MemToRegM(MemToRegM), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
        .WriteDataM(WriteDataM)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_age: -1 no MUL in EX, 1..RUN_CYCLES iterating, RUN_CYCLES+1 result ready.
    int          m_age = -1;
    logic [63:0] m_prod = '0;
    logic        e_rw = 0, e_mw = 0, e_mr = 0, e_mtr = 0, e_bub = 0;
    logic [4:0]  e_rd = '0;
    logic [63:0] e_alu = '0, e_wd = '0;
    logic [63:0] t_a, t_fb, t_b;

    function automatic logic [63:0] m_fwd(input logic [1:0] s, input logic [63:0] rd);
        if (s == 2'b01) return ResultW;
        if (s == 2'b10) return e_alu;
        return rd;
    endfunction

    function automatic logic [63:0] m_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a ^ b;
            3'd4: return a << b[5:0];
            3'd5: return a >> b[5:0];
            3'd6: return a - b;
            default: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        endcase
    endfunction

    function automatic logic m_busy();
        return (m_age < 0 && MulE && !FlushE) || (m_age >= 1 && m_age <= RUN_CYCLES) ||
               (m_age == RUN_CYCLES + 1 && StallM);
    endfunction

    function automatic logic m_pcsrc();
        logic [63:0] a, b;
        a = m_fwd(ForwardAE, RD1_E);
        b = ALUSrcE ? Imm_E : m_fwd(ForwardBE, RD2_E);
        return !FlushE && ((BEQ_E && a == b) || (BNE_E && a != b) || JAL_E || JALR_E);
    endfunction

    function automatic logic [63:0] m_target();
        logic [63:0] a;
        a = m_fwd(ForwardAE, RD1_E);
        return JALR_E ? ((a + Imm_E) & ~64'd1) : (PCE + Imm_E);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_age = -1; m_prod = '0;
            e_rw = 0; e_mw = 0; e_mr = 0; e_mtr = 0; e_bub = 0; e_rd = '0; e_alu = '0; e_wd = '0;
        end else begin
            t_a  = m_fwd(ForwardAE, RD1_E);
            t_fb = m_fwd(ForwardBE, RD2_E);
            t_b  = ALUSrcE ? Imm_E : t_fb;
            if (!StallM) begin
                if (FlushE || (m_age < 0 && MulE) || (m_age >= 1 && m_age <= RUN_CYCLES)) begin
                    e_rw = 0; e_mw = 0; e_mr = 0; e_mtr = 0; e_rd = '0; e_alu = '0; e_wd = '0; e_bub = 1;
                end else begin
                    e_rw = RegWriteE; e_mw = MemWriteE; e_mr = MemReadE; e_mtr = MemToRegE;
                    e_rd = RD_E; e_wd = t_fb; e_bub = 0;
                    if (m_age == RUN_CYCLES + 1) e_alu = m_prod;
                    else if (JAL_E || JALR_E)    e_alu = PCE + 64'd4;
                    else                         e_alu = m_alu(ALUOpE, t_a, t_b);
                end
            end
            if (FlushE) m_age = -1;
            else if (m_age < 0) begin
                if (MulE) begin m_prod = t_a * t_b; m_age = 1; end
            end
            else if (m_age <= RUN_CYCLES) m_age++;
            else if (!StallM) m_age = -1;
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(BusyE), 64'(m_busy()));
        check("pcsrc", 64'(PCSrcE), 64'(m_pcsrc()));
        check("pctarget", PCTargetE, m_target());
        check("regwrite_m", 64'(RegWriteM), 64'(e_rw));
        check("memwrite_m", 64'(MemWriteM), 64'(e_mw));
        check("memread_m", 64'(MemReadM), 64'(e_mr));
        check("rd_m", 64'(RD_M), 64'(e_rd));
        if (!e_bub) begin
            check("memtoreg_m", 64'(MemToRegM), 64'(e_mtr));
            check("alu_result_m", ALU_ResultM, e_alu);
            check("writedata_m", WriteDataM, e_wd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        RegWriteE = 0; MemWriteE = 0; MemReadE = 0; MemToRegE = 0; ALUSrcE = 0;
        ALUOpE = 3'd0; MulE = 0; BEQ_E = 0; BNE_E = 0; JAL_E = 0; JALR_E = 0;
        RD1_E = '0; RD2_E = '0; Imm_E = '0; PCE = '0; ResultW = '0; RD_E = '0;
        ForwardAE = 2'b00; ForwardBE = 2'b00; StallM = 0; FlushE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string name, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] expv);
        idle_inputs();
        ALUOpE = op; RD1_E = a; RD2_E = b; RegWriteE = 1; RD_E = 5'd10;
        tick();
        check(name, ALU_ResultM, expv);
    endtask

    // Issues a MUL and returns in its result-ready cycle; operands change
    // after capture to show they are not re-read.
    task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                           output int n);
        idle_inputs();
        MulE = 1; RegWriteE = 1; RD1_E = a; RD2_E = b; RD_E = rd;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (!BusyE) break;
            n++;
            tick();
            if (n == 1) begin RD1_E = 64'd99; RD2_E = 64'd77; end
        end
    endtask

    int n;
    logic [63:0] held_alu;

    initial begin
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_regwrite", 64'(RegWriteM), 64'd0);
        check("rst_alu", ALU_ResultM, 64'd0);
        check("rst_rd", 64'(RD_M), 64'd0);
        check("rst_busy", 64'(BusyE), 64'd0);
        @(negedge clk) reset = 1'b1;
        tick();

        // ADD with writeback forwarding on A.
        idle_inputs();
        RD1_E = 64'd5; ResultW = 64'd10; ForwardAE = 2'b01; RD2_E = 64'd20;
        ALUOpE = 3'b010; RegWriteE = 1; RD_E = 5'd7;
        tick();
        check("add_fwd", ALU_ResultM, 64'd30);
        check("add_fwd_rw", 64'(RegWriteM), 64'd1);
        check("add_fwd_rd", 64'(RD_M), 64'd7);

        alu_vec("and",      3'd0, 64'hF0F0, 64'hFF00, 64'hF000);
        alu_vec("or",       3'd1, 64'hF0F0, 64'h0F0F, 64'hFFFF);
        alu_vec("xor",      3'd3, 64'hFF, 64'h0F, 64'hF0);
        alu_vec("sll_mask", 3'd4, 64'd1, 64'h43, 64'd8);
        alu_vec("srl_63",   3'd5, 64'h8000_0000_0000_0000, 64'd63, 64'd1);
        alu_vec("sub_wrap", 3'd6, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE);
        alu_vec("add_wrap", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        alu_vec("slt_neg",  3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        alu_vec("slt_pos",  3'd7, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        alu_vec("add_5",    3'd2, 64'd2, 64'd3, 64'd5);

        // Forward from ALU_ResultM (currently 5).
        idle_inputs();
        RD1_E = 64'd1000; ForwardAE = 2'b10; RD2_E = 64'd1; ALUOpE = 3'd2;
        tick();
        check("fwd_mem", ALU_ResultM, 64'd6);

        // Store: immediate address, forwarded store data.
        idle_inputs();
        MemWriteE = 1; ALUSrcE = 1; Imm_E = 64'd8; RD1_E = 64'd100;
        RD2_E = 64'd5; ResultW = 64'hABCD; ForwardBE = 2'b01; ALUOpE = 3'd2;
        tick();
        check("store_addr", ALU_ResultM, 64'd108);
        check("store_data", WriteDataM, 64'hABCD);
        check("store_mw", 64'(MemWriteM), 64'd1);

        // Branches.
        idle_inputs();
        BEQ_E = 1; RD1_E = 64'd30; RD2_E = 64'd30; PCE = 64'd100; Imm_E = 64'd16; ALUOpE = 3'd6;
        #1;
        check("beq_taken", 64'(PCSrcE), 64'd1);
        check("beq_target", PCTargetE, 64'd116);
        RD1_E = 64'd31;
        #1;
        check("beq_not_taken", 64'(PCSrcE), 64'd0);
        BEQ_E = 0; BNE_E = 1;
        #1;
        check("bne_taken", 64'(PCSrcE), 64'd1);
        tick();
        JAL_E = 1; BNE_E = 0; FlushE = 1;
        #1;
        check("flush_kills_pcsrc", 64'(PCSrcE), 64'd0);
        tick();

        idle_inputs();
        JALR_E = 1; RD1_E = 64'd201; Imm_E = 64'd4; PCE = 64'd40; RegWriteE = 1; RD_E = 5'd1;
        #1;
        check("jalr_target", PCTargetE, 64'd204);
        check("jalr_pcsrc", 64'(PCSrcE), 64'd1);
        tick();
        check("jalr_link", ALU_ResultM, 64'd44);

        idle_inputs();
        JAL_E = 1; PCE = 64'd1000; Imm_E = 64'hFFFF_FFFF_FFFF_FFF8;
        #1;
        check("jal_target", PCTargetE, 64'd992);
        tick();

        // MUL 7 x (-3).
        run_mul(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, n);
        check("mul_busy_cycles", 64'(n), 64'd17);
        check("mul_bubble_rw", 64'(RegWriteM), 64'd0);
        tick();
        check("mul_result", ALU_ResultM, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mul_rw", 64'(RegWriteM), 64'd1);
        check("mul_rd", 64'(RD_M), 64'd5);
        idle_inputs();
        tick();

        // MUL aborted by FlushE in its fifth RUN cycle.
        idle_inputs();
        MulE = 1; RegWriteE = 1; RD1_E = 64'd5; RD2_E = 64'd6; RD_E = 5'd9;
        repeat (5) tick();
        FlushE = 1;
        tick();
        FlushE = 0; MulE = 0; RegWriteE = 0;
        #1;
        check("abort_busy_low", 64'(BusyE), 64'd0);
        repeat (20) tick();

        run_mul(64'd3, 64'd4, 5'd6, n);
        check("mul2_busy_cycles", 64'(n), 64'd17);
        tick();
        check("mul2_result", ALU_ResultM, 64'd12);
        idle_inputs();
        tick();

        // StallM held in DONE for three cycles.
        run_mul(64'd9, 64'd9, 5'd3, n);
        StallM = 1;
        #1;
        held_alu = ALU_ResultM;
        for (int i = 0; i < 3; i++) begin
            check("stall_busy", 64'(BusyE), 64'd1);
            @(posedge clk);
            #2;
            check("stall_hold_alu", ALU_ResultM, held_alu);
            check("stall_hold_rw", 64'(RegWriteM), 64'd0);
        end
        StallM = 0;
        #1;
        check("stall_release_busy", 64'(BusyE), 64'd0);
        tick();
        check("stall_result", ALU_ResultM, 64'd81);
        check("stall_rw", 64'(RegWriteM), 64'd1);
        check("stall_rd", 64'(RD_M), 64'd3);
        idle_inputs();
        tick();

        // Reset in the middle of a MUL while EX/MEM holds an earlier result.
        alu_vec("pre_reset_add", 3'd2, 64'd40, 64'd2, 64'd42);
        idle_inputs();
        MulE = 1; StallM = 1; RD1_E = 64'd2; RD2_E = 64'd2;
        repeat (4) tick();
        check("stall_during_run", ALU_ResultM, 64'd42);
        #2;
        reset = 1'b0; MulE = 0; StallM = 0;
        #1;
        check("midrst_alu", ALU_ResultM, 64'd0);
        check("midrst_rw", 64'(RegWriteM), 64'd0);
        check("midrst_rd", 64'(RD_M), 64'd0);
        check("midrst_busy", 64'(BusyE), 64'd0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Full MUL after reset: (-1) x (-1) wraps to 1.
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, n);
        check("mul3_busy_cycles", 64'(n), 64'd17);
        tick();
        check("mul3_result", ALU_ResultM, 64'd1);
        idle_inputs();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
